// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NREQ byte sources.
// It locks the grant across a packet, tracks the busy handshake and owns the baud select.
//
// state     | meaning
// IDLE      | arbitrate; baud select follows baud_cfg
// LOAD      | one-cycle tx_wr strobe, timeout counter cleared
// WAIT_BUSY | wait for tx_busy to rise, bounded by BUSY_TIMEOUT
// WAIT_DONE | wait for tx_busy to fall
// ACK       | ack pulse to the owner; keep or release the lock
module uart_tx_arbiter #(
    parameter int NREQ         = 4,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    input  logic [2:0]        baud_cfg,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   ack,
    output logic              tx_en,
    output logic              tx_wr,
    output logic [7:0]        tx_data,
    input  logic              tx_busy,
    output logic [2:0]        tx_baud_select,
    output logic              err_timeout
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_WAIT_BUSY, S_WAIT_DONE, S_ACK
    } state_t;

    state_t          state, state_next;
    logic [PW-1:0]   ptr, winner, winner_inc, pick;
    logic [NREQ-1:0] pick_oh, winner_oh;
    logic            pick_vld, locked, last_q, timeout_hit;
    logic [7:0]      cnt;

    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int offs);
        int s;
        s = int'(base) + offs;
        if (s >= NREQ) s = s - NREQ;
        return PW'(s);
    endfunction

    // Walk from the farthest offset back to ptr so the nearest request is written last.
    always_comb begin
        pick     = winner;
        pick_vld = 1'b0;
        if (locked) begin
            pick_vld = req[winner];
        end else begin
            for (int i = NREQ - 1; i >= 0; i--) begin
                if (req[wrap_add(ptr, i)]) begin
                    pick     = wrap_add(ptr, i);
                    pick_vld = 1'b1;
                end
            end
        end
    end

    assign pick_oh     = {{(NREQ-1){1'b0}}, 1'b1} << pick;
    assign winner_oh   = {{(NREQ-1){1'b0}}, 1'b1} << winner;
    assign winner_inc  = (winner == PW'(NREQ - 1)) ? '0 : winner + 1'b1;
    assign timeout_hit = (state == S_WAIT_BUSY) && !tx_busy && (cnt == 8'(BUSY_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:      if (pick_vld) state_next = S_LOAD;
            S_LOAD:      state_next = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (tx_busy)          state_next = S_WAIT_DONE;
                else if (timeout_hit) state_next = S_IDLE;
            end
            S_WAIT_DONE: if (!tx_busy) state_next = S_ACK;
            S_ACK:       state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    always_comb begin
        tx_wr = (state == S_LOAD);
        tx_en = (state == S_LOAD) || (state == S_WAIT_BUSY) || (state == S_WAIT_DONE);
        ack   = (state == S_ACK) ? winner_oh : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr            <= '0;
            winner         <= '0;
            locked         <= 1'b0;
            last_q         <= 1'b0;
            grant          <= '0;
            cnt            <= '0;
            tx_data        <= 8'hFF;
            tx_baud_select <= 3'b111;
            err_timeout    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    tx_baud_select <= baud_cfg;
                    if (pick_vld) begin
                        winner  <= pick;
                        grant   <= pick_oh;
                        tx_data <= req_data[8*pick +: 8];
                        last_q  <= req_last[pick];
                    end
                end
                S_LOAD: cnt <= '0;
                S_WAIT_BUSY: begin
                    if (timeout_hit) begin
                        err_timeout <= 1'b1;
                        locked      <= 1'b0;
                        grant       <= '0;
                        ptr         <= winner_inc;
                    end else if (!tx_busy) begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_ACK: begin
                    if (last_q) begin
                        locked <= 1'b0;
                        grant  <= '0;
                        ptr    <= winner_inc;
                    end else begin
                        locked <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: per-requester byte sources, a busy-handshake
// transmitter model, and per-scenario checks against expected grant/data/ack sequences.
module tb_uart_tx_arbiter;
    localparam int NREQ         = 4;
    localparam int BUSY_TIMEOUT = 16;

    logic              clk      = 1'b0;
    logic              reset    = 1'b1;
    logic [NREQ-1:0]   req      = '0;
    logic [NREQ-1:0]   req_last = '0;
    logic [8*NREQ-1:0] req_data = '0;
    logic [2:0]        baud_cfg = 3'b111;
    logic              tx_busy  = 1'b0;
    logic [NREQ-1:0]   grant, ack;
    logic              tx_en, tx_wr, err_timeout;
    logic [7:0]        tx_data;
    logic [2:0]        tx_baud_select;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NREQ(NREQ), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data), .req_last(req_last),
        .baud_cfg(baud_cfg), .grant(grant), .ack(ack), .tx_en(tx_en), .tx_wr(tx_wr),
        .tx_data(tx_data), .tx_busy(tx_busy), .tx_baud_select(tx_baud_select),
        .err_timeout(err_timeout)
    );

    // Transmitter model: busy rises one cycle after tx_wr and stays high busy_len cycles.
    bit model_on = 1'b1;
    int busy_len = 10;
    int bcnt     = 0;
    bit pend     = 1'b0;
    always @(posedge clk) begin
        #1;
        if (reset) begin
            tx_busy = 1'b0; pend = 1'b0; bcnt = 0;
        end else if (pend) begin
            pend = 1'b0; tx_busy = 1'b1; bcnt = busy_len;
        end else if (bcnt > 0) begin
            bcnt--;
            if (bcnt == 0) tx_busy = 1'b0;
        end else if (tx_wr && model_on) begin
            pend = 1'b1;
        end
    end

    logic [8:0] src [NREQ][4];
    int src_len [NREQ];
    int src_pos [NREQ];
    int src_gap [NREQ];
    int gap_left[NREQ];

    logic [NREQ-1:0] exp_g[$];
    logic [7:0]      exp_d[$];
    logic [NREQ-1:0] obs_g[$];
    logic [7:0]      obs_d[$];
    int              obs_wc[$];
    logic [NREQ-1:0] obs_a[$];
    int              obs_ac[$];

    task automatic clear_src();
        for (int i = 0; i < NREQ; i++) begin
            src_len[i] = 0; src_pos[i] = 0; src_gap[i] = 0; gap_left[i] = 0;
        end
        req = '0; req_last = '0;
        exp_g.delete(); exp_d.delete();
        obs_g.delete(); obs_d.delete(); obs_wc.delete(); obs_a.delete(); obs_ac.delete();
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        clear_src();
        model_on = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic add_byte(input int i, input logic [7:0] d, input logic last);
        src[i][src_len[i]] = {last, d};
        src_len[i]++;
    endtask

    task automatic expect_tx(input logic [NREQ-1:0] g, input logic [7:0] d);
        exp_g.push_back(g);
        exp_d.push_back(d);
    endtask

    // One cycle: record DUT activity, retire acked bytes and present the next ones.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (tx_wr) begin
            obs_g.push_back(grant); obs_d.push_back(tx_data); obs_wc.push_back(cyc);
        end
        if (ack != '0) begin
            obs_a.push_back(ack); obs_ac.push_back(cyc);
        end
        for (int i = 0; i < NREQ; i++) begin
            if (ack[i]) begin
                src_pos[i]++;
                gap_left[i] = src_gap[i];
            end else if (gap_left[i] > 0) begin
                gap_left[i]--;
            end
            req[i] = (gap_left[i] == 0) && (src_pos[i] < src_len[i]);
            if (src_pos[i] < src_len[i]) begin
                req_data[8*i +: 8] = src[i][src_pos[i]][7:0];
                req_last[i]        = src[i][src_pos[i]][8];
            end
        end
    endtask

    task automatic run_until(input int n_acks, input int budget, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < budget; t++) begin
            step();
            if (obs_a.size() >= n_acks) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pad_obs();
        while (obs_g.size() < exp_g.size()) begin
            obs_g.push_back('x); obs_d.push_back('x); obs_wc.push_back(-1000);
        end
        while (obs_a.size() < exp_g.size()) begin
            obs_a.push_back('x); obs_ac.push_back(-1000);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++; if (grant !== 4'b0000) begin n_err++; $display("FAIL reset_grant: got %b want 0000", grant); end
        n_cmp++; if (ack !== 4'b0000) begin n_err++; $display("FAIL reset_ack: got %b want 0000", ack); end
        n_cmp++; if (tx_en !== 1'b0) begin n_err++; $display("FAIL reset_tx_en: got %b want 0", tx_en); end
        n_cmp++; if (tx_wr !== 1'b0) begin n_err++; $display("FAIL reset_tx_wr: got %b want 0", tx_wr); end
        n_cmp++; if (tx_data !== 8'hFF) begin n_err++; $display("FAIL reset_tx_data: got %h want ff", tx_data); end
        n_cmp++; if (tx_baud_select !== 3'b111) begin n_err++; $display("FAIL reset_baud: got %b want 111", tx_baud_select); end
        n_cmp++; if (err_timeout !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", err_timeout); end
    endtask

    task automatic test_single_byte();
        bit ok;
        apply_reset();
        add_byte(0, 8'h89, 1'b1);
        step();
        step();
        n_cmp++;
        if (tx_wr !== 1'b1 || grant !== 4'b0001 || tx_data !== 8'h89) begin
            n_err++;
            $display("FAIL single_load: got wr=%b grant=%b data=%h want wr=1 grant=0001 data=89", tx_wr, grant, tx_data);
        end
        run_until(1, 100, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL single_ack_wait: got no ack within 100 cycles want ack"); end
        expect_tx(4'b0001, 8'h89);
        pad_obs();
        n_cmp++; if (obs_a[0] !== 4'b0001) begin n_err++; $display("FAIL single_ack: got %b want 0001", obs_a[0]); end
        n_cmp++;
        if (obs_ac[0] - obs_wc[0] != 12) begin
            n_err++; $display("FAIL single_ack_latency: got %0d want 12 cycles after tx_wr", obs_ac[0] - obs_wc[0]);
        end
        step();
        n_cmp++; if (ack !== 4'b0000) begin n_err++; $display("FAIL single_ack_pulse: got %b want 0000", ack); end
        n_cmp++; if (grant !== 4'b0000) begin n_err++; $display("FAIL single_grant_release: got %b want 0000", grant); end
    endtask

    task automatic test_round_robin();
        bit ok, b2b_bad;
        apply_reset();
        for (int i = 0; i < NREQ; i++) begin
            add_byte(i, 8'h10 + 8'(i), 1'b1);
            add_byte(i, 8'h20 + 8'(i), 1'b1);
        end
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NREQ; i++)
                expect_tx(4'b0001 << i, (r == 0 ? 8'h10 : 8'h20) + 8'(i));
        run_until(8, 400, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL rr_wait: got %0d acks want 8", obs_a.size()); end
        pad_obs();
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (obs_g[k] !== exp_g[k] || obs_d[k] !== exp_d[k] || obs_a[k] !== exp_g[k]) begin
                n_err++;
                $display("FAIL rr_byte[%0d]: got grant=%b data=%h ack=%b want grant=%b data=%h ack=%b",
                         k, obs_g[k], obs_d[k], obs_a[k], exp_g[k], exp_d[k], exp_g[k]);
            end
        end
        b2b_bad = 1'b0;
        for (int k = 0; k < 7; k++)
            if (obs_wc[k+1] - obs_ac[k] != 2) b2b_bad = 1'b1;
        n_cmp++; if (b2b_bad) begin n_err++; $display("FAIL rr_back_to_back: got gap!=2 want tx_wr 2 cycles after ack"); end
    endtask

    task automatic test_packet_lock();
        bit ok, lock_bad;
        apply_reset();
        add_byte(1, 8'h55, 1'b0);
        add_byte(1, 8'hCC, 1'b1);
        src_gap[1] = 5;
        add_byte(0, 8'h77, 1'b1);
        gap_left[0] = 2;
        expect_tx(4'b0010, 8'h55);
        expect_tx(4'b0010, 8'hCC);
        expect_tx(4'b0001, 8'h77);
        ok = 1'b0; lock_bad = 1'b0;
        for (int t = 0; t < 300; t++) begin
            step();
            if (obs_a.size() == 1 && obs_g.size() == 1 && grant !== 4'b0010) lock_bad = 1'b1;
            if (obs_a.size() >= 3) begin ok = 1'b1; break; end
        end
        n_cmp++; if (!ok) begin n_err++; $display("FAIL lock_wait: got %0d acks want 3", obs_a.size()); end
        pad_obs();
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (obs_g[k] !== exp_g[k] || obs_d[k] !== exp_d[k] || obs_a[k] !== exp_g[k]) begin
                n_err++;
                $display("FAIL lock_byte[%0d]: got grant=%b data=%h ack=%b want grant=%b data=%h ack=%b",
                         k, obs_g[k], obs_d[k], obs_a[k], exp_g[k], exp_d[k], exp_g[k]);
            end
        end
        n_cmp++; if (lock_bad) begin n_err++; $display("FAIL lock_grant_gap: got grant change want 0010 held"); end
        n_cmp++;
        if (obs_wc[1] - obs_ac[0] != 6) begin
            n_err++; $display("FAIL lock_gap_resume: got %0d want 6 cycles ack-to-wr", obs_wc[1] - obs_ac[0]);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int err_cyc, acks_at_err;
        logic [NREQ-1:0] grant_at_err;
        apply_reset();
        model_on = 1'b0;
        add_byte(2, 8'hA5, 1'b1);
        add_byte(3, 8'h3C, 1'b1);
        expect_tx(4'b0100, 8'hA5);
        expect_tx(4'b1000, 8'h3C);
        expect_tx(4'b0100, 8'hA5);
        ok = 1'b0; err_cyc = -1; acks_at_err = -1; grant_at_err = 'x;
        for (int t = 0; t < 300; t++) begin
            step();
            if (err_timeout === 1'b1 && err_cyc < 0) begin
                err_cyc = cyc; acks_at_err = obs_a.size(); grant_at_err = grant;
                model_on = 1'b1;
            end
            if (obs_a.size() >= 2) begin ok = 1'b1; break; end
        end
        n_cmp++; if (!ok) begin n_err++; $display("FAIL to_wait: got %0d acks want 2", obs_a.size()); end
        pad_obs();
        n_cmp++;
        if (err_cyc - obs_wc[0] != BUSY_TIMEOUT + 1) begin
            n_err++; $display("FAIL to_boundary: got err %0d cycles after tx_wr want %0d", err_cyc - obs_wc[0], BUSY_TIMEOUT + 1);
        end
        n_cmp++; if (acks_at_err != 0) begin n_err++; $display("FAIL to_no_ack: got %0d acks want 0", acks_at_err); end
        n_cmp++; if (grant_at_err !== 4'b0000) begin n_err++; $display("FAIL to_grant_clear: got %b want 0000", grant_at_err); end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (obs_g[k] !== exp_g[k] || obs_d[k] !== exp_d[k]) begin
                n_err++;
                $display("FAIL to_wr[%0d]: got grant=%b data=%h want grant=%b data=%h", k, obs_g[k], obs_d[k], exp_g[k], exp_d[k]);
            end
        end
        n_cmp++;
        if (obs_a[0] !== 4'b1000 || obs_a[1] !== 4'b0100) begin
            n_err++; $display("FAIL to_acks: got %b,%b want 1000,0100", obs_a[0], obs_a[1]);
        end
        n_cmp++; if (err_timeout !== 1'b1) begin n_err++; $display("FAIL to_sticky: got %b want 1", err_timeout); end
    endtask

    task automatic test_baud_update();
        bit ok, sel_bad;
        int busy_seen;
        logic [2:0] sel_ack, sel_idle, sel_next;
        baud_cfg = 3'b111;
        apply_reset();
        add_byte(0, 8'h42, 1'b1);
        ok = 1'b0; sel_bad = 1'b0; busy_seen = 0; sel_ack = 'x;
        for (int t = 0; t < 100; t++) begin
            step();
            if (tx_busy) begin
                busy_seen++;
                if (busy_seen == 2) baud_cfg = 3'b011;
                else if (busy_seen > 2 && tx_baud_select !== 3'b111) sel_bad = 1'b1;
            end
            if (obs_a.size() > 0) begin sel_ack = tx_baud_select; ok = 1'b1; break; end
        end
        step(); sel_idle = tx_baud_select;
        step(); sel_next = tx_baud_select;
        n_cmp++; if (!ok) begin n_err++; $display("FAIL baud_wait: got no ack within 100 cycles want ack"); end
        n_cmp++; if (sel_bad) begin n_err++; $display("FAIL baud_busy: got change during transfer want 111"); end
        n_cmp++; if (sel_ack !== 3'b111) begin n_err++; $display("FAIL baud_ack: got %b want 111", sel_ack); end
        n_cmp++; if (sel_idle !== 3'b111) begin n_err++; $display("FAIL baud_idle_entry: got %b want 111", sel_idle); end
        n_cmp++; if (sel_next !== 3'b011) begin n_err++; $display("FAIL baud_after_idle: got %b want 011", sel_next); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int busy_cnt;
        baud_cfg = 3'b011;
        apply_reset();
        add_byte(0, 8'h11, 1'b1);
        add_byte(1, 8'h22, 1'b1);
        ok = 1'b0; busy_cnt = 0;
        for (int t = 0; t < 200; t++) begin
            step();
            if (obs_g.size() == 2 && tx_busy) busy_cnt++;
            if (busy_cnt == 3) begin ok = 1'b1; break; end
        end
        n_cmp++; if (!ok) begin n_err++; $display("FAIL rmid_reach: got no WAIT_DONE within 200 cycles want WAIT_DONE"); end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (tx_data !== 8'hFF || grant !== 4'b0000 || tx_en !== 1'b0 || ack !== 4'b0000) begin
            n_err++;
            $display("FAIL rmid_values: got data=%h grant=%b en=%b ack=%b want ff 0000 0 0000", tx_data, grant, tx_en, ack);
        end
        n_cmp++; if (tx_baud_select !== 3'b111) begin n_err++; $display("FAIL rmid_baud: got %b want 111", tx_baud_select); end
        reset = 1'b0;
        clear_src();
        add_byte(0, 8'h33, 1'b1);
        add_byte(1, 8'h44, 1'b1);
        expect_tx(4'b0001, 8'h33);
        expect_tx(4'b0010, 8'h44);
        run_until(2, 100, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL rmid_restart_wait: got %0d acks want 2", obs_a.size()); end
        pad_obs();
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (obs_g[k] !== exp_g[k] || obs_d[k] !== exp_d[k] || obs_a[k] !== exp_g[k]) begin
                n_err++;
                $display("FAIL rmid_restart[%0d]: got grant=%b data=%h ack=%b want grant=%b data=%h ack=%b",
                         k, obs_g[k], obs_d[k], obs_a[k], exp_g[k], exp_d[k], exp_g[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_round_robin();
        test_packet_lock();
        test_timeout();
        test_baud_update();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion by 1ms want completion");
        $fatal(1);
    end
endmodule
